// File: rtl/glitch_filter.sv
// Multi-channel deglitcher: per-channel synchroniser followed by a run-length
// filter. A channel's filtered level only moves once the synchronised input
// has disagreed with it for STABLE consecutive enabled samples.

// One channel: sync chain, run counter, filtered level and edge strobes.
module glitch_filter_ch #(
  parameter int STABLE      = 4,
  parameter int SYNC_STAGES = 2,
  parameter bit RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy_nxt
);
  localparam int CW = (STABLE > 1) ? $clog2(STABLE + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(STABLE - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_q;
  logic                   r_rise;
  logic                   r_fall;

  logic [CW-1:0]          w_cnt_nxt;
  logic                   w_q_nxt;
  logic                   w_rise_nxt;
  logic                   w_fall_nxt;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  // Synchroniser runs every cycle; only the filter below is gated by en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= {SYNC_STAGES{RST_VAL}};
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], d};
  end

  // Run-length decision: a sample matching q rejects the run; the STABLE-th
  // mismatching sample commits the new level and fires the matching strobe.
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_q_nxt    = r_q;
    w_rise_nxt = 1'b0;
    w_fall_nxt = 1'b0;
    if (en) begin
      if (w_s == r_q) begin
        w_cnt_nxt = '0;
      end else if (r_cnt == LAST) begin
        w_cnt_nxt  = '0;
        w_q_nxt    = w_s;
        w_rise_nxt = w_s;
        w_fall_nxt = ~w_s;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  // Filter state and registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_q    <= RST_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_q    <= w_q_nxt;
      r_rise <= w_rise_nxt;
      r_fall <= w_fall_nxt;
    end
  end

  assign q        = r_q;
  assign rise     = r_rise;
  assign fall     = r_fall;
  assign busy_nxt = (w_cnt_nxt != '0);
endmodule

// Top: CH independent channels plus a shared registered busy flag.
module glitch_filter #(
  parameter int CH          = 4,
  parameter int STABLE      = 4,
  parameter int SYNC_STAGES = 2,
  parameter bit RST_VAL     = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [CH-1:0] d,
  output logic [CH-1:0] q,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall,
  output logic          busy
);
  logic [CH-1:0] w_busy_nxt;
  logic          r_busy;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    glitch_filter_ch #(
      .STABLE      (STABLE),
      .SYNC_STAGES (SYNC_STAGES),
      .RST_VAL     (RST_VAL)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .d        (d[i]),
      .q        (q[i]),
      .rise     (rise[i]),
      .fall     (fall[i]),
      .busy_nxt (w_busy_nxt[i])
    );
  end

  // busy tracks the counters as they are written, so it rises with the first
  // mismatching sample rather than a cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= 1'b0;
    else        r_busy <= |w_busy_nxt;
  end

  assign busy = r_busy;
endmodule

// File: tb/tb_glitch_filter.sv
`timescale 1ns/100ps
module tb_glitch_filter;
  localparam int CH = 4;
  localparam int STABLE = 4;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b1;
  logic [CH-1:0] d = '1;
  logic [CH-1:0] q, rise, fall;
  logic          busy;

  int errors = 0;
  int checks = 0;

  glitch_filter #(.CH(CH), .STABLE(STABLE), .SYNC_STAGES(SS), .RST_VAL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .d(d),
    .q(q), .rise(rise), .fall(fall), .busy(busy)
  );

  always #20 clk = ~clk;

  // Reference model: delay line for the synchroniser, then a history of all
  // enabled samples. A channel accepts a new level when the most recent
  // STABLE enabled samples since its last change all disagree with it.
  bit [CH-1:0] m_dl [SS];
  bit [CH-1:0] hist [$];
  int          base [CH];
  bit [CH-1:0] m_q, m_rise, m_fall;
  bit          m_busy;

  function automatic int trail(int c);
    int t = 0;
    for (int k = hist.size() - 1; k >= base[c]; k--) begin
      if (hist[k][c] != m_q[c]) t++;
      else break;
    end
    return t;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit [CH-1:0] s;
    if (!rst_n) begin
      for (int i = 0; i < SS; i++) m_dl[i] = '0;
      hist.delete();
      for (int c = 0; c < CH; c++) base[c] = 0;
      m_q = '0; m_rise = '0; m_fall = '0; m_busy = 1'b0;
    end else begin
      s = m_dl[SS-1];
      for (int i = SS - 1; i > 0; i--) m_dl[i] = m_dl[i-1];
      m_dl[0] = d;
      m_rise = '0; m_fall = '0;
      if (en) begin
        hist.push_back(s);
        for (int c = 0; c < CH; c++) begin
          if (trail(c) >= STABLE) begin
            if (s[c]) m_rise[c] = 1'b1;
            else      m_fall[c] = 1'b1;
            m_q[c] = s[c];
            base[c] = hist.size();
          end
        end
      end
      m_busy = 1'b0;
      for (int c = 0; c < CH; c++) begin
        int t;
        t = trail(c);
        if (t > 0 && t < STABLE) m_busy = 1'b1;
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; d = 4'hF; en = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if ({q, rise, fall, busy} !== 13'd0) begin
        errors++;
        $display("FAIL reset: q=%h rise=%h fall=%h busy=%b, want all 0", q, rise, fall, busy);
      end
    end
    d = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    @(negedge clk);
    d[0] = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      @(negedge clk);
      checks++;
      if (q[0] !== (e >= 5) || rise[0] !== (e == 5) || fall !== '0 || busy !== (e >= 2 && e <= 4)) begin
        errors++;
        $display("FAIL latency edge %0d: q0=%b rise0=%b fall=%h busy=%b, want q0=%b rise0=%b fall=0 busy=%b",
                 e, q[0], rise[0], fall, busy, e >= 5, e == 5, e >= 2 && e <= 4);
      end
    end
  endtask

  task automatic test_glitch();
    bit rise_seen = 1'b0;
    d[0] = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (q[0] !== 1'b0) begin
      errors++;
      $display("FAIL glitch_setup: q0=%b, want 0", q[0]);
    end
    fork
      begin
        #3 d[0] = 1'b1;
        #60 d[0] = 1'b0;
        repeat (6) begin
          #22 d[0] = 1'b1;
          #2  d[0] = 1'b0;
          #2;
        end
      end
      begin
        repeat (10) begin
          @(negedge clk);
          if (rise[0]) rise_seen = 1'b1;
          checks++;
          if ({q, rise, fall, busy} !== {m_q, m_rise, m_fall, m_busy}) begin
            errors++;
            $display("FAIL glitch_model: q=%h rise=%h fall=%h busy=%b, want q=%h rise=%h fall=%h busy=%b",
                     q, rise, fall, busy, m_q, m_rise, m_fall, m_busy);
          end
        end
      end
    join
    repeat (6) @(negedge clk);
    checks++;
    if (q[0] !== 1'b0 || rise_seen || busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch: q0=%b rise_seen=%b busy=%b, want 0 0 0", q[0], rise_seen, busy);
    end
  endtask

  task automatic test_simul();
    d = 4'b0100;
    repeat (8) @(negedge clk);
    checks++;
    if (q !== 4'b0100) begin
      errors++;
      $display("FAIL simul_setup: q=%h, want 4", q);
    end
    d = 4'b0010;
    for (int e = 0; e <= 6; e++) begin
      @(negedge clk);
      checks++;
      if (rise !== ((e == 5) ? 4'b0010 : 4'b0000) || fall !== ((e == 5) ? 4'b0100 : 4'b0000) ||
          q !== ((e >= 5) ? 4'b0010 : 4'b0100)) begin
        errors++;
        $display("FAIL simul edge %0d: q=%h rise=%h fall=%h", e, q, rise, fall);
      end
    end
  endtask

  task automatic test_enable();
    d[3] = 1'b1;
    for (int k = 0; k <= 15; k++) begin
      en = (k % 3 == 0);
      @(negedge clk);
      checks++;
      if (q[3] !== (k >= 12) || rise[3] !== (k == 12) ||
          {q, rise, fall, busy} !== {m_q, m_rise, m_fall, m_busy}) begin
        errors++;
        $display("FAIL enable k=%0d: q=%h rise=%h busy=%b, want q3=%b model q=%h rise=%h busy=%b",
                 k, q, rise, busy, k >= 12, m_q, m_rise, m_busy);
      end
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    d[0] = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || q[0] !== 1'b0) begin
      errors++;
      $display("FAIL midreset_pre: busy=%b q0=%b, want 1 0", busy, q[0]);
    end
    #5 rst_n = 1'b0;
    #1;
    checks++;
    if ({q, rise, fall, busy} !== 13'd0) begin
      errors++;
      $display("FAIL midreset_async: q=%h rise=%h fall=%h busy=%b, want 0", q, rise, fall, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e <= 6; e++) begin
      @(negedge clk);
      checks++;
      if (q !== ((e >= 5) ? d : 4'b0000) || rise !== ((e == 5) ? d : 4'b0000)) begin
        errors++;
        $display("FAIL midreset edge %0d: q=%h rise=%h, want q=%h rise=%h",
                 e, q, rise, (e >= 5) ? d : 4'b0000, (e == 5) ? d : 4'b0000);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 5) == 0) d[c] = ~d[c];
      en = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      checks++;
      if ({q, rise, fall, busy} !== {m_q, m_rise, m_fall, m_busy}) begin
        errors++;
        $display("FAIL random cyc %0d: q=%h rise=%h fall=%h busy=%b, want q=%h rise=%h fall=%h busy=%b",
                 k, q, rise, fall, busy, m_q, m_rise, m_fall, m_busy);
      end
    end
    en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_simul();
    test_enable();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
